// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down counter with modulus, variable step, load/clear, wrap or saturate
module updown_counter_n #(
   parameter int WIDTH    = 8,
   parameter int MAX_VAL  = 2**WIDTH-1,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             up_down,
   input  logic [WIDTH-1:0] step,
   output logic [WIDTH-1:0] count,
   output logic             ovf,
   output logic             unf,
   output logic             at_max,
   output logic             at_min
);

   if (WIDTH < 2) begin : g_bad_width
      $error("updown_counter_n: WIDTH must be at least 2");
   end
   if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_max
      $error("updown_counter_n: MAX_VAL out of range");
   end

   localparam logic [WIDTH:0] MAX_EXT   = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] RANGE_EXT = MAX_EXT + 1'b1;

   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   logic [WIDTH:0] cnt_ext;
   logic [WIDTH:0] step_ext;
   logic [WIDTH:0] load_ext;
   logic [WIDTH:0] s_ext;
   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] nxt_ext;

   always_comb begin
      cnt_ext  = {1'b0, count_q};
      step_ext = {1'b0, step};
      load_ext = {1'b0, load_val};
      s_ext    = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
      sum_ext  = cnt_ext + s_ext;
      nxt_ext  = cnt_ext;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;

      if (clr) begin
         nxt_ext = '0;
      end else if (load) begin
         nxt_ext = (load_ext > MAX_EXT) ? MAX_EXT : load_ext;
      end else if (en) begin
         if (up_down) begin
            if (sum_ext <= MAX_EXT) begin
               nxt_ext = sum_ext;
            end else begin
               ovf_d   = 1'b1;
               nxt_ext = SATURATE ? MAX_EXT : (sum_ext - RANGE_EXT);
            end
         end else begin
            if (cnt_ext >= s_ext) begin
               nxt_ext = cnt_ext - s_ext;
            end else begin
               // wrap adds the modulus before subtracting so the (WIDTH+1)-bit math never goes negative
               unf_d   = 1'b1;
               nxt_ext = SATURATE ? '0 : (cnt_ext + RANGE_EXT - s_ext);
            end
         end
      end

      count_d = nxt_ext[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   assign count  = count_q;
   assign ovf    = ovf_q;
   assign unf    = unf_q;
   assign at_max = (count_q == MAX_EXT[WIDTH-1:0]);
   assign at_min = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// tb/tb_updown_counter_n.sv - directed table-driven bench for updown_counter_n
module tb_updown_counter_n;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   // shared stimulus for the two WIDTH=4, MAX_VAL=9 instances
   logic       clr = 1'b0, load = 1'b0, en = 1'b0, up_down = 1'b0;
   logic [3:0] load_val = '0, step = '0;
   // stimulus for the full-range WIDTH=8 instance
   logic       c_clr = 1'b0, c_load = 1'b0, c_en = 1'b0, c_up_down = 1'b0;
   logic [7:0] c_load_val = '0, c_step = '0;

   logic [3:0] a_count, b_count;
   logic [7:0] c_count;
   logic a_ovf, a_unf, a_max, a_min;
   logic b_ovf, b_unf, b_max, b_min;
   logic c_ovf, c_unf, c_max, c_min;

   updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_down(up_down), .step(step), .count(a_count),
      .ovf(a_ovf), .unf(a_unf), .at_max(a_max), .at_min(a_min));

   updown_counter_n #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
      .clk(clk), .rstn(rstn), .clr(clr), .load(load), .load_val(load_val),
      .en(en), .up_down(up_down), .step(step), .count(b_count),
      .ovf(b_ovf), .unf(b_unf), .at_max(b_max), .at_min(b_min));

   updown_counter_n #(.WIDTH(8)) u_full (
      .clk(clk), .rstn(rstn), .clr(c_clr), .load(c_load), .load_val(c_load_val),
      .en(c_en), .up_down(c_up_down), .step(c_step), .count(c_count),
      .ovf(c_ovf), .unf(c_unf), .at_max(c_max), .at_min(c_min));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply(input logic c, input logic l, input logic [3:0] lv,
                        input logic e, input logic ud, input logic [3:0] st);
      clr = c; load = l; load_val = lv; en = e; up_down = ud; step = st;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_c(input logic l, input logic [7:0] lv, input logic e,
                          input logic ud, input logic [7:0] st);
      c_clr = 1'b0; c_load = l; c_load_val = lv; c_en = e; c_up_down = ud; c_step = st;
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic       clr;
      logic       load;
      logic [3:0] load_val;
      logic       en;
      logic       up_down;
      logic [3:0] step;
      logic [3:0] exp_count;
      logic       exp_ovf;
      logic       exp_unf;
      logic       exp_max;
      logic       exp_min;
   } vec_t;

   vec_t vecs[$];

   initial begin
      // basic up count 1..9 then wrap, ovf only on 9->0
      for (int i = 1; i <= 9; i++)
         vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'(i), 1'b0, 1'b0, (i == 9), 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0});
      // load 2, down step 3: 2 -> 9 (unf) -> 6
      vecs.push_back('{1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0});
      // priority and clamping
      vecs.push_back('{1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 4'd15, 1'b1, 1'b1, 4'd1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0});
      // hold with en low, and with zero step
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0});
      // exact landing on 0 is not an underflow; one more step down wraps
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0});

      // reset held for 2 cycles
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_a_count", a_count, 0);
      chk("rst_a_ovf", a_ovf, 0);
      chk("rst_a_unf", a_unf, 0);
      chk("rst_a_at_min", a_min, 1);
      chk("rst_a_at_max", a_max, 0);
      chk("rst_b_count", b_count, 0);
      chk("rst_c_count", c_count, 0);
      rstn = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].up_down, vecs[i].step);
         chk($sformatf("vec%0d_count", i), a_count, vecs[i].exp_count);
         chk($sformatf("vec%0d_ovf", i), a_ovf, vecs[i].exp_ovf);
         chk($sformatf("vec%0d_unf", i), a_unf, vecs[i].exp_unf);
         chk($sformatf("vec%0d_at_max", i), a_max, vecs[i].exp_max);
         chk($sformatf("vec%0d_at_min", i), a_min, vecs[i].exp_min);
      end

      // saturate: 8 up by 4 -> 9,9,9 with ovf each edge; down by 5 -> 4,0,0
      apply(1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 4'd0);
      chk("sat_load", b_count, 8);
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd4);
         chk($sformatf("sat_up%0d_count", i), b_count, 9);
         chk($sformatf("sat_up%0d_ovf", i), b_ovf, 1);
         chk($sformatf("sat_up%0d_at_max", i), b_max, 1);
      end
      apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5);
      chk("sat_dn0_count", b_count, 4);
      chk("sat_dn0_unf", b_unf, 0);
      chk("sat_dn0_ovf", b_ovf, 0);
      for (int i = 1; i < 3; i++) begin
         apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5);
         chk($sformatf("sat_dn%0d_count", i), b_count, 0);
         chk($sformatf("sat_dn%0d_unf", i), b_unf, 1);
         chk($sformatf("sat_dn%0d_at_min", i), b_min, 1);
      end

      // asynchronous reset mid-cycle from count 7
      apply(1'b0, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0);
      chk("arst_pre_count", a_count, 7);
      en = 1'b1; up_down = 1'b1; step = 4'd1; load = 1'b0;
      #3;
      rstn = 1'b0;
      #1;
      chk("arst_count", a_count, 0);
      chk("arst_ovf", a_ovf, 0);
      chk("arst_unf", a_unf, 0);
      chk("arst_at_min", a_min, 1);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_first_count", a_count, 1);

      // full-range instance: 250 + 10 wraps to 4 with ovf, then holds
      apply_c(1'b1, 8'd250, 1'b0, 1'b0, 8'd0);
      chk("full_load", c_count, 250);
      apply_c(1'b0, 8'd0, 1'b1, 1'b1, 8'd10);
      chk("full_wrap_count", c_count, 4);
      chk("full_wrap_ovf", c_ovf, 1);
      for (int i = 0; i < 3; i++) begin
         apply_c(1'b0, 8'd0, 1'b0, 1'b1, 8'd10);
         chk($sformatf("full_hold%0d_count", i), c_count, 4);
         chk($sformatf("full_hold%0d_ovf", i), c_ovf, 0);
      end
      apply_c(1'b1, 8'd255, 1'b0, 1'b0, 8'd0);
      chk("full_at_max", c_max, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
